ahb_bridge_arbiter: RTL

Two-requester arbiter and transfer sequencer for the UART command path (requester 0) and the slave4-interface path (requester 1).
- Shares one AHB master port between the two requesters.
- Grants the port round-robin and drives one single-beat transfer per grant through an address phase and a data phase.
- Returns read data, a completion pulse and a timeout error to the granted requester.
- Sits between the UART/slave4 front ends and the AHB master interface.

---
 rtl/ahb_bridge_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ahb_bridge_arbiter.sv
// ahb_bridge_arbiter
// Two-requester round-robin arbiter and single-beat AHB transfer sequencer.
// Requester 0 is the UART command path and requester 1 is the slave4-interface
// path. Each grant runs one address phase and one data phase on the shared
// AHB master port. The data phase ends either when the slave signals ready or
// when the wait-state timeout expires, which also raises an error.
// There is only ever one transfer in flight.

module ahb_bridge_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              write0,
  input  logic              write1,
  input  logic [1:0]        sel0,
  input  logic [1:0]        sel1,
  input  logic              hready,
  input  logic [DATA_W-1:0] hrdata,
  output logic [1:0]        hgrant,
  output logic [ADDR_W-1:0] haddr,
  output logic              hwrite,
  output logic [1:0]        hsel,
  output logic [1:0]        htrans,
  output logic [DATA_W-1:0] hwdata,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        done,
  output logic              err,
  output logic              busy
);

  // The wait counter only has to reach TIMEOUT-1. The final wait cycle
  // is recognised by comparing against that value, not by counting past it.
  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_ptr;
  logic               r_gnt;
  logic [DATA_W-1:0]  r_wdata;
  logic [CNT_W-1:0]   r_cnt;

  logic [1:0]         w_elig;
  logic               w_pickValid;
  logic               w_pick;
  logic [1:0]         w_pickOh;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_wdata;
  logic               w_write;
  logic [1:0]         w_sel;
  logic               w_lastWait;

  // Choose the next requester. A requester whose done is still high is masked
  // so that a request held into its own completion cycle cannot be re-granted.
  always_comb begin
    w_elig      = req & ~done;
    w_pickValid = |w_elig;
    w_pick      = 1'b0;
    case (w_elig)
      2'b10:   w_pick = 1'b1;
      2'b11:   w_pick = r_ptr;
      default: w_pick = 1'b0;
    endcase
  end

  assign w_pickOh   = w_pick ? 2'b10 : 2'b01;
  assign w_addr     = w_pick ? addr1  : addr0;
  assign w_wdata    = w_pick ? wdata1 : wdata0;
  assign w_write    = w_pick ? write1 : write0;
  assign w_sel      = w_pick ? sel1   : sel0;
  assign w_lastWait = (r_cnt == CNT_LAST);

  // Transfer sequencer. Every output is a register, and completion clears the
  // grant in the same edge that raises done.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b0;
      r_gnt   <= 1'b0;
      r_wdata <= '0;
      r_cnt   <= '0;
      hgrant  <= 2'b00;
      haddr   <= '0;
      hwrite  <= 1'b0;
      hsel    <= 2'b00;
      htrans  <= HTRANS_IDLE;
      hwdata  <= '0;
      rdata   <= '0;
      done    <= 2'b00;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= 2'b00;
      err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          htrans <= HTRANS_IDLE;
          hwdata <= '0;
          if (w_pickValid) begin
            r_state <= S_ADDR;
            r_gnt   <= w_pick;
            r_wdata <= w_wdata;
            hgrant  <= w_pickOh;
            haddr   <= w_addr;
            hwrite  <= w_write;
            hsel    <= w_sel;
            htrans  <= HTRANS_NONSEQ;
            busy    <= 1'b1;
          end
        end

        S_ADDR: begin
          r_state <= S_DATA;
          r_cnt   <= '0;
          htrans  <= HTRANS_IDLE;
          hwdata  <= hwrite ? r_wdata : '0;
        end

        S_DATA: begin
          if (hready || w_lastWait) begin
            if (hready && !hwrite) begin
              rdata <= hrdata;
            end
            err     <= !hready;
            done    <= r_gnt ? 2'b10 : 2'b01;
            r_state <= S_IDLE;
            r_ptr   <= ~r_gnt;
            r_cnt   <= '0;
            hgrant  <= 2'b00;
            hwdata  <= '0;
            busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          hgrant  <= 2'b00;
          htrans  <= HTRANS_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
